// File: rtl/alu_decoder_pipe_pkg.sv
// Shared encodings for the ALU decoder pipe: ALU control codes, ALUOpcode values,
// funct7 patterns and MDU wait FSM states.
package alu_decoder_pipe_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational ALU decode of ALUOpcode/funct3/funct7/opcode5 into {alu_ctrl, illegal, is_mdu}.
// Any illegal encoding collapses to ADD with is_mdu cleared.
module alu_decode_comb
  import alu_decoder_pipe_pkg::*;
#(
  parameter int ENABLE_M = 1,
  parameter int CTRL_W   = 5
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              opcode5,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              is_mdu
);

  logic [4:0] code;
  logic       bad;
  logic       mdu;
  logic       f7_legal;

  always_comb begin
    code     = ALU_ADD;
    bad      = 1'b0;
    mdu      = 1'b0;
    f7_legal = 1'b1;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        if (opcode5 && funct7 == F7_MEXT) begin
          mdu = (ENABLE_M != 0);
          bad = (ENABLE_M == 0);
          case (funct3)
            3'd0:    code = ALU_MUL;
            3'd1:    code = ALU_MULH;
            3'd2:    code = ALU_MULHSU;
            3'd3:    code = ALU_MULHU;
            3'd4:    code = ALU_DIV;
            3'd5:    code = ALU_DIVU;
            3'd6:    code = ALU_REM;
            default: code = ALU_REMU;
          endcase
        end else begin
          case (funct3)
            3'b000:  code = (opcode5 && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
          // I-type immediates occupy funct7 except for the shift forms.
          if (opcode5) begin
            f7_legal = (funct7 == F7_BASE) ||
                       (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
          end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
            f7_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT && funct3 == 3'b101);
          end
          bad = !f7_legal;
        end
      end
      ALUOP_RSVD: bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    if (bad) begin
      code = ALU_ADD;
      mdu  = 1'b0;
    end
  end

  assign alu_ctrl = CTRL_W'(code);
  assign illegal  = bad;
  assign is_mdu   = mdu;

endmodule

// File: rtl/alu_decoder_pipe.sv
// Registered valid/ready ALU decoder; 1-cycle latency, full throughput except after an MDU op,
// which blocks issue until its entry is taken and then for MUL_LAT/DIV_LAT busy cycles.
module alu_decoder_pipe
  import alu_decoder_pipe_pkg::*;
#(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 32,
  parameter int CTRL_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOpcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              opcode5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              is_mdu,
  output logic              mdu_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_mdu;

  logic              out_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              illegal_q;
  logic              is_mdu_q;
  logic              mdu_busy_q;
  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;
  logic take;

  alu_decode_comb #(
    .ENABLE_M (ENABLE_M),
    .CTRL_W   (CTRL_W)
  ) u_decode (
    .alu_op   (ALUOpcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .opcode5  (opcode5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .is_mdu   (dec_mdu)
  );

  // A held MDU entry must not be replaced: its take is what starts the wait.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || (out_ready && !is_mdu_q));
  assign accept   = in_valid && in_ready;
  assign take     = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= CTRL_W'(ALU_ADD);
      illegal_q   <= 1'b0;
      is_mdu_q    <= 1'b0;
      mdu_busy_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        alu_ctrl_q  <= dec_ctrl;
        illegal_q   <= dec_illegal;
        is_mdu_q    <= dec_mdu;
      end else if (take) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (take && is_mdu_q) begin
            state_q    <= ST_WAIT;
            mdu_busy_q <= 1'b1;
            // Bit 2 of an M code separates DIV/REM (20..23) from MUL (16..19).
            cnt_q      <= alu_ctrl_q[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= ST_IDLE;
            mdu_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign illegal   = illegal_q;
  assign is_mdu    = is_mdu_q;
  assign mdu_busy  = mdu_busy_q;

endmodule

// File: tb/tb_alu_decoder_pipe.sv
// Scoreboard bench for alu_decoder_pipe: directed reset/stream/backpressure/MDU/illegal cases,
// then a random legal/illegal mix under random out_ready checked against a reference decode.
module tb_alu_decoder_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOpcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       opcode5;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] alu_ctrl;
  logic       illegal;
  logic       is_mdu;
  logic       mdu_busy;

  logic       n_in_ready;
  logic       n_out_valid;
  logic [3:0] n_alu_ctrl;
  logic       n_illegal;
  logic       n_is_mdu;
  logic       n_mdu_busy;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       ill;
    logic       mdu;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_acc, last_busy, last_in_ready;

  alu_decoder_pipe #(.ENABLE_M(1), .MUL_LAT(3), .DIV_LAT(32), .CTRL_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOpcode(ALUOpcode), .funct3(funct3), .funct7(funct7), .opcode5(opcode5),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .is_mdu(is_mdu), .mdu_busy(mdu_busy)
  );

  alu_decoder_pipe #(.ENABLE_M(0), .MUL_LAT(3), .DIV_LAT(32), .CTRL_W(4)) dut_nom (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .ALUOpcode(ALUOpcode), .funct3(funct3), .funct7(funct7), .opcode5(opcode5),
    .out_valid(n_out_valid), .out_ready(out_ready), .alu_ctrl(n_alu_ctrl),
    .illegal(n_illegal), .is_mdu(n_is_mdu), .mdu_busy(n_mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode for ENABLE_M=1.
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic o5);
    exp_t r;
    logic [4:0] base [8];
    logic ok;
    base = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};
    r = '0;
    if (op == 2'b01) r.ctrl = 5'd1;
    else if (op == 2'b11) r.ill = 1'b1;
    else if (op == 2'b10) begin
      if (o5 && f7 == 7'h01) begin
        r.mdu  = 1'b1;
        r.ctrl = 5'd16 + {2'b00, f3};
      end else begin
        r.ctrl = base[f3];
        if (f3 == 3'd0 && o5 && f7[5]) r.ctrl = 5'd1;
        if (f3 == 3'd5 && f7[5]) r.ctrl = 5'd9;
        if (o5) ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1 || f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        else ok = 1'b1;
        if (!ok) begin
          r.ill  = 1'b1;
          r.ctrl = 5'd0;
        end
      end
    end
    return r;
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    last_busy     = mdu_busy;
    last_in_ready = in_ready;
    last_acc      = in_valid && in_ready;
    if (mdu_busy) begin
      check_eq("busy_blocks_in", 32'(in_ready), 0);
      check_eq("busy_no_out", 32'(out_valid), 0);
    end
    if (out_valid && out_ready) begin
      check_eq("sb_nonempty", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_eq("ctrl", 32'(alu_ctrl), 32'(e.ctrl));
        check_eq("illegal", 32'(illegal), 32'(e.ill));
        check_eq("is_mdu", 32'(is_mdu), 32'(e.mdu));
      end
    end
    if (last_acc) sbq.push_back(model(ALUOpcode, funct3, funct7, opcode5));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic o5, output int cyc);
    ALUOpcode = op; funct3 = f3; funct7 = f7; opcode5 = o5; in_valid = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!last_acc && cyc < 200);
    check_eq("send_accepted", 32'(last_acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while ((sbq.size() != 0 || mdu_busy || out_valid) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_empty", 32'(sbq.size()), 0);
  endtask

  task automatic measure_busy(output int nb);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_busy) nb++;
      else break;
    end
  endtask

  initial begin
    int cyc, nb, sent, r;
    logic [1:0] op;
    logic [6:0] f7;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOpcode = 2'b00; funct3 = 3'd0; funct7 = 7'd0; opcode5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_alu_ctrl", 32'(alu_ctrl), 0);
    check_eq("rst_illegal", 32'(illegal), 0);
    check_eq("rst_is_mdu", 32'(is_mdu), 0);
    check_eq("rst_mdu_busy", 32'(mdu_busy), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T2: back-to-back ADD, SUB, SRAI, SLTU with out_ready high.
    send(2'b10, 3'd0, 7'h00, 1'b1, cyc); check_eq("t2_cyc_add", cyc, 1);
    send(2'b10, 3'd0, 7'h20, 1'b1, cyc); check_eq("t2_cyc_sub", cyc, 1);
    send(2'b10, 3'd5, 7'h20, 1'b0, cyc); check_eq("t2_cyc_srai", cyc, 1);
    send(2'b10, 3'd3, 7'h00, 1'b1, cyc); check_eq("t2_cyc_sltu", cyc, 1);
    drain();

    // T3: XOR held under backpressure while AND waits upstream.
    send(2'b10, 3'd4, 7'h00, 1'b1, cyc);
    out_ready = 1'b0;
    ALUOpcode = 2'b10; funct3 = 3'd7; funct7 = 7'h00; opcode5 = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t3_hold_vld", 32'(out_valid), 1);
      check_eq("t3_hold_ctrl", 32'(alu_ctrl), 4);
      check_eq("t3_in_rdy", 32'(last_in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    check_eq("t3_resume_acc", 32'(last_acc), 1);
    drain();

    // T4: MUL then DIV occupancy.
    send(2'b10, 3'd0, 7'h01, 1'b1, cyc);
    step();
    check_eq("t4_mul_take_blocks", 32'(last_in_ready), 0);
    measure_busy(nb);
    check_eq("t4_mul_busy_cycles", nb, 3);
    check_eq("t4_mul_in_rdy_after", 32'(last_in_ready), 1);
    send(2'b10, 3'd4, 7'h01, 1'b1, cyc);
    step();
    measure_busy(nb);
    check_eq("t4_div_busy_cycles", nb, 32);
    check_eq("t4_div_in_rdy_after", 32'(last_in_ready), 1);
    drain();

    // T5: illegal encodings; M encoding on the ENABLE_M=0 instance.
    send(2'b10, 3'd0, 7'h01, 1'b1, cyc);
    check_eq("t5_nom_vld", 32'(n_out_valid), 1);
    check_eq("t5_nom_illegal", 32'(n_illegal), 1);
    check_eq("t5_nom_ctrl", 32'(n_alu_ctrl), 0);
    check_eq("t5_nom_mdu", 32'(n_is_mdu), 0);
    step();
    step();
    check_eq("t5_nom_no_wait", 32'(n_mdu_busy), 0);
    drain();
    send(2'b11, 3'd0, 7'h00, 1'b0, cyc);
    step(); step();
    check_eq("t5_rsvd_no_wait", 32'(last_busy), 0);
    send(2'b10, 3'd4, 7'h20, 1'b1, cyc);
    step(); step();
    check_eq("t5_xor_alt_no_wait", 32'(last_busy), 0);
    send(2'b10, 3'd1, 7'h20, 1'b0, cyc);
    step(); step();
    check_eq("t5_slli_alt_no_wait", 32'(last_busy), 0);
    drain();

    // T1: reset in the middle of a DIV wait.
    send(2'b10, 3'd4, 7'h01, 1'b1, cyc);
    step();
    repeat (3) step();
    check_eq("t1_busy_before_rst", 32'(last_busy), 1);
    reset = 1'b1;
    #1;
    check_eq("t1_rst_busy", 32'(mdu_busy), 0);
    check_eq("t1_rst_vld", 32'(out_valid), 0);
    check_eq("t1_rst_ctrl", 32'(alu_ctrl), 0);
    check_eq("t1_rst_ill", 32'(illegal), 0);
    check_eq("t1_rst_mdu", 32'(is_mdu), 0);
    @(posedge clk);
    #1;
    check_eq("t1_edge_busy", 32'(mdu_busy), 0);
    reset = 1'b0;
    #1;
    check_eq("t1_in_rdy_after", 32'(in_ready), 1);
    check_eq("t1_sb_empty", 32'(sbq.size()), 0);
    @(posedge clk);
    #1;

    // T6: random mix with random downstream stalls.
    sent = 0;
    for (int c = 0; c < 20000 && sent < 200; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 10);
        op = (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : (r == 9) ? 2'b01 : 2'b11;
        r = $urandom_range(0, 3);
        f7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : (r == 2) ? 7'h01 : 7'($urandom_range(0, 127));
        ALUOpcode = op; funct3 = 3'($urandom_range(0, 7)); funct7 = f7;
        opcode5 = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (last_acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check_eq("t6_all_sent", sent, 200);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
